sd_card_cmd_responder: RTL

SD_CARD_CMD_RESPONDER -- requirements
Module: sd_card_cmd_responder

---
 rtl/sd_card_cmd_responder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sd_card_cmd_responder.sv
// SD card CMD-line responder: receives 48-bit host command frames and checks
// their CRC7, then drives a short (48-bit) or long (136-bit) response frame
// from a descriptor supplied by the card logic.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | CMD line idle, watching for a start bit
// RX       | shifting in the remaining 47 bits of a host command
// WAIT_RSP | good command decoded, waiting for a response descriptor
// NCR      | descriptor latched, holding off until the Ncr gap is met
// TX       | driving the response frame onto the CMD line
module sd_card_cmd_responder #(
  parameter int NcrCycles = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_en_o,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         cmd_crc_err_o,
  output logic         cmd_end_err_o,
  output logic         rsp_ready_o,
  input  logic         rsp_valid_i,
  input  logic         rsp_none_i,
  input  logic         rsp_long_i,
  input  logic         rsp_no_crc_i,
  input  logic [5:0]   rsp_index_i,
  input  logic [31:0]  rsp_arg_i,
  input  logic [126:0] rsp_long_data_i
);

  typedef enum logic [2:0] {IDLE, RX, WAIT_RSP, NCR, TX} state_t;

  // Counter value seen in the cycle after the end bit; reaching zero marks
  // the earliest cycle from which an accept may launch the start bit next.
  localparam logic [5:0] NCR_LOAD = 6'(NcrCycles - 2);

  state_t         state, state_nxt;
  logic [5:0]     rx_cnt;
  logic [44:0]    rx_sr;
  logic [6:0]     rx_crc;
  logic [5:0]     ncr_cnt;
  logic [7:0]     tx_cnt;
  logic [135:0]   tx_sr;
  logic           crc_ok;
  logic           accept;
  logic           rx_last;
  logic [6:0]     rsp_crc;
  logic [135:0]   tx_frame;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
  endfunction

  function automatic logic [6:0] crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) c = crc7_step(c, d[i]);
    return c;
  endfunction

  // Frame decode helpers and the response frame built from the live descriptor
  always_comb begin
    rx_last  = (state == RX) && (rx_cnt == 6'd0);
    crc_ok   = (rx_crc == rx_sr[6:0]);
    accept   = (state == WAIT_RSP) && rsp_valid_i;
    rsp_crc  = rsp_no_crc_i ? 7'h7F : crc7_40({2'b00, rsp_index_i, rsp_arg_i});
    if (rsp_long_i)
      tx_frame = {2'b00, 6'h3F, rsp_long_data_i, 1'b1};
    else
      tx_frame = {2'b00, rsp_index_i, rsp_arg_i, rsp_crc, 1'b1, 88'd0};
  end

  // Next-state logic and line outputs
  always_comb begin
    state_nxt   = state;
    rsp_ready_o = 1'b0;
    cmd_en_o    = 1'b0;
    cmd_o       = 1'b1;
    case (state)
      IDLE: if (!cmd_i) state_nxt = RX;
      RX: begin
        if (rx_cnt == 6'd46 && !cmd_i)
          state_nxt = IDLE;
        else if (rx_cnt == 6'd0)
          state_nxt = (crc_ok && cmd_i) ? WAIT_RSP : IDLE;
      end
      WAIT_RSP: begin
        rsp_ready_o = 1'b1;
        if (rsp_valid_i) begin
          if (rsp_none_i)             state_nxt = IDLE;
          else if (ncr_cnt == 6'd0)   state_nxt = TX;
          else                        state_nxt = NCR;
        end
      end
      NCR: if (ncr_cnt == 6'd0) state_nxt = TX;
      TX: begin
        cmd_en_o = 1'b1;
        cmd_o    = tx_sr[135];
        if (tx_cnt == 8'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // Receive shifter, CRC accumulator and decoded-command outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_cnt        <= 6'd0;
      rx_sr         <= '0;
      rx_crc        <= 7'd0;
      cmd_valid_o   <= 1'b0;
      cmd_crc_err_o <= 1'b0;
      cmd_end_err_o <= 1'b0;
      cmd_index_o   <= 6'd0;
      cmd_arg_o     <= 32'd0;
    end else begin
      cmd_valid_o   <= 1'b0;
      cmd_crc_err_o <= 1'b0;
      cmd_end_err_o <= 1'b0;
      if (state == IDLE && !cmd_i) begin
        // start bit is 0, so it leaves a zero-initialised CRC unchanged
        rx_cnt <= 6'd46;
        rx_sr  <= '0;
        rx_crc <= 7'd0;
      end else if (state == RX) begin
        if (rx_cnt != 6'd0) begin
          rx_sr  <= {rx_sr[43:0], cmd_i};
          rx_cnt <= rx_cnt - 6'd1;
          if (rx_cnt >= 6'd8) rx_crc <= crc7_step(rx_crc, cmd_i);
        end
        if (rx_last) begin
          cmd_crc_err_o <= !crc_ok;
          cmd_end_err_o <= crc_ok && !cmd_i;
          cmd_valid_o   <= crc_ok && cmd_i;
          if (crc_ok && cmd_i) begin
            cmd_index_o <= rx_sr[44:39];
            cmd_arg_o   <= rx_sr[38:7];
          end
        end
      end
    end
  end

  // Ncr hold-off down-counter, started at the end bit of a good command
  always_ff @(posedge clk_i) begin
    if (rst_i)
      ncr_cnt <= 6'd0;
    else if (rx_last)
      ncr_cnt <= NCR_LOAD;
    else if ((state == WAIT_RSP || state == NCR) && ncr_cnt != 6'd0)
      ncr_cnt <= ncr_cnt - 6'd1;
  end

  // Response shifter: loaded on accept so later descriptor changes are ignored
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_sr  <= '0;
      tx_cnt <= 8'd0;
    end else if (accept && !rsp_none_i) begin
      tx_sr  <= tx_frame;
      tx_cnt <= rsp_long_i ? 8'd135 : 8'd47;
    end else if (state == TX) begin
      tx_sr  <= {tx_sr[134:0], 1'b0};
      tx_cnt <= tx_cnt - 8'd1;
    end
  end

endmodule
